// File: rtl/wallace_final_cpa_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wallace_final_cpa_if : operand/result handshake bundle of the final CPA stage
// Revision 1.0
// ----------------------------------------------------------------------------
interface wallace_final_cpa_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_u;
  logic [WIDTH-1:0] in_v;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_u, in_v, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_tag
  );

  modport slave (
    input  in_valid, in_u, in_v, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/wallace_final_cpa.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wallace_final_cpa : pipelined CHUNK-bit-per-stage ripple adder resolving the
//                     multiplier's final carry-save pair into a binary product
// Revision 1.0
// ----------------------------------------------------------------------------
module wallace_final_cpa #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  wallace_final_cpa_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic advance_w;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;  // operand bits still unresolved on entry

    logic                src_valid_w;
    logic                src_carry_w;
    logic [TAG_W-1:0]    src_tag_w;
    logic [REM-1:0]      src_u_w;
    logic [REM-1:0]      src_v_w;
    logic [CHUNK:0]      sum_d;
    logic [LO+CHUNK-1:0] res_d;

    logic                valid_q;
    logic                carry_q;
    logic [TAG_W-1:0]    tag_q;
    logic [LO+CHUNK-1:0] res_q;

    if (k == 0) begin : g_head
      assign src_valid_w = bus.in_valid;
      assign src_carry_w = 1'b0;
      assign src_tag_w   = bus.in_tag;
      assign src_u_w     = bus.in_u;
      assign src_v_w     = bus.in_v;
      assign res_d       = sum_d[CHUNK-1:0];
    end else begin : g_body
      assign src_valid_w = g_stage[k-1].valid_q;
      assign src_carry_w = g_stage[k-1].carry_q;
      assign src_tag_w   = g_stage[k-1].tag_q;
      assign src_u_w     = g_stage[k-1].g_skew.skew_u_q;
      assign src_v_w     = g_stage[k-1].g_skew.skew_v_q;
      assign res_d       = {sum_d[CHUNK-1:0], g_stage[k-1].res_q};
    end

    assign sum_d = {1'b0, src_u_w[CHUNK-1:0]} + {1'b0, src_v_w[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, src_carry_w};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        tag_q   <= '0;
        res_q   <= '0;
      end else if (advance_w) begin
        valid_q <= src_valid_w;
        carry_q <= sum_d[CHUNK];
        tag_q   <= src_tag_w;
        res_q   <= res_d;
      end
    end

    // Upper chunks not yet added travel alongside until their stage is reached.
    if (k < STAGES - 1) begin : g_skew
      logic [REM-CHUNK-1:0] skew_u_q;
      logic [REM-CHUNK-1:0] skew_v_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skew_u_q <= '0;
          skew_v_q <= '0;
        end else if (advance_w) begin
          skew_u_q <= src_u_w[REM-1:CHUNK];
          skew_v_q <= src_v_w[REM-1:CHUNK];
        end
      end
    end
  end

  // The whole pipe moves as one unit; a held result freezes every stage.
  assign advance_w     = bus.out_ready | ~g_stage[STAGES-1].valid_q;
  assign bus.in_ready  = advance_w;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.out_sum   = g_stage[STAGES-1].res_q;
  assign bus.out_cout  = g_stage[STAGES-1].carry_q;
  assign bus.out_tag   = g_stage[STAGES-1].tag_q;
endmodule
`default_nettype wire

// File: tb/tb_wallace_final_cpa.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wallace_final_cpa : directed self-checking bench for wallace_final_cpa
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_wallace_final_cpa;
  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int TAG_W = 4;
  localparam int LAT   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  wallace_final_cpa_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  wallace_final_cpa #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [WIDTH-1:0] dir_u   [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
                                    64'h0123_4567_89AB_CDEF, 64'h0000_FFFF_0000_FFFF,
                                    64'h8000_0000_0000_0000};
  logic [WIDTH-1:0] dir_v   [5] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000,
                                    64'h1111_1111_1111_1110, 64'h0000_0001_0000_0002,
                                    64'h8000_0000_0000_0000};
  logic [TAG_W-1:0] dir_tag [5] = '{4'd3, 4'd5, 4'd6, 4'd9, 4'd15};
  logic [WIDTH-1:0] dir_sum [5] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFE_0000_0001,
                                    64'h1234_5678_9ABC_DEFF, 64'h0001_0000_0001_0001,
                                    64'h0000_0000_0000_0000};
  logic             dir_co  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    bus.in_u = '0; bus.in_v = '0; bus.in_tag = '0;
    rst = 1'b1;
    #2;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    tests_run++;
    if (bus.out_sum !== '0) begin
      tests_failed++; $display("FAIL reset_out_sum: got %h expected 0", bus.out_sum);
    end
    tests_run++;
    if (bus.out_cout !== 1'b0 || bus.out_tag !== '0) begin
      tests_failed++; $display("FAIL reset_cout_tag: got %b/%h expected 0/0", bus.out_cout, bus.out_tag);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_u = dir_u[i]; bus.in_v = dir_v[i]; bus.in_tag = dir_tag[i];
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c < LAT; c++) begin
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
          tests_failed++; $display("FAIL dir%0d_early_valid cycle %0d: got %b expected 0", i, c, bus.out_valid);
        end
        tick();
      end
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== dir_sum[i] || bus.out_cout !== dir_co[i]
          || bus.out_tag !== dir_tag[i]) begin
        tests_failed++;
        $display("FAIL dir%0d_result: got v=%b sum=%h co=%b tag=%h expected v=1 sum=%h co=%b tag=%h",
                 i, bus.out_valid, bus.out_sum, bus.out_cout, bus.out_tag, dir_sum[i], dir_co[i], dir_tag[i]);
      end
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL dir%0d_duplicate: got out_valid %b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_stream();
    localparam int N = 100;
    logic [WIDTH-1:0] su [N];
    logic [WIDTH-1:0] sv [N];
    logic [WIDTH-1:0] es [N];
    logic             ec [N];
    logic             exp_v;
    for (int i = 0; i < N; i++) begin
      su[i] = {$urandom, $urandom};
      sv[i] = (i % 10 == 0) ? ~su[i] + 64'd1 : {$urandom, $urandom};
      {ec[i], es[i]} = {1'b0, su[i]} + {1'b0, sv[i]};
    end
    for (int c = 0; c < N + LAT + 1; c++) begin
      if (c < N) begin
        bus.in_valid = 1'b1; bus.in_u = su[c]; bus.in_v = sv[c]; bus.in_tag = TAG_W'(c);
      end else begin
        idle();
      end
      #1;
      tests_run++;
      if (bus.in_ready !== 1'b1) begin
        tests_failed++; $display("FAIL stream_in_ready cycle %0d: got %b expected 1", c, bus.in_ready);
      end
      exp_v = (c >= LAT) && (c - LAT < N);
      tests_run++;
      if (bus.out_valid !== exp_v) begin
        tests_failed++; $display("FAIL stream_out_valid cycle %0d: got %b expected %b", c, bus.out_valid, exp_v);
      end else if (exp_v) begin
        tests_run++;
        if (bus.out_sum !== es[c-LAT] || bus.out_cout !== ec[c-LAT] || bus.out_tag !== TAG_W'(c - LAT)) begin
          tests_failed++;
          $display("FAIL stream_result %0d: got sum=%h co=%b tag=%h expected sum=%h co=%b tag=%h", c - LAT,
                   bus.out_sum, bus.out_cout, bus.out_tag, es[c-LAT], ec[c-LAT], TAG_W'(c - LAT));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic [WIDTH-1:0] pu [N];
    logic [WIDTH-1:0] pv [N];
    logic [WIDTH-1:0] ps [N];
    logic             pc [N];
    int sent = 0;
    int recv = 0;
    int c    = 0;
    for (int i = 0; i < N; i++) begin
      pu[i] = {$urandom, $urandom};
      pv[i] = {$urandom, $urandom};
      {pc[i], ps[i]} = {1'b0, pu[i]} + {1'b0, pv[i]};
    end
    while (recv < N && c < 60) begin
      bus.out_ready = !(c >= 4 && c <= 8);
      if (sent < N) begin
        bus.in_valid = 1'b1; bus.in_u = pu[sent]; bus.in_v = pv[sent]; bus.in_tag = TAG_W'(sent);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 8) begin
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
          tests_failed++; $display("FAIL bp_in_ready stall cycle %0d: got %b expected 0", c, bus.in_ready);
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_sum !== ps[0] || bus.out_tag !== TAG_W'(0)) begin
          tests_failed++;
          $display("FAIL bp_frozen cycle %0d: got v=%b sum=%h tag=%h expected v=1 sum=%h tag=0",
                   c, bus.out_valid, bus.out_sum, bus.out_tag, ps[0]);
        end
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (bus.out_sum !== ps[recv] || bus.out_cout !== pc[recv] || bus.out_tag !== TAG_W'(recv)) begin
          tests_failed++;
          $display("FAIL bp_result %0d: got sum=%h co=%b tag=%h expected sum=%h co=%b tag=%h", recv,
                   bus.out_sum, bus.out_cout, bus.out_tag, ps[recv], pc[recv], TAG_W'(recv));
        end
        recv++;
      end
      tick();
      c++;
    end
    idle();
    tests_run++;
    if (recv != N || sent != N) begin
      tests_failed++; $display("FAIL bp_count: got sent=%0d recv=%0d expected %0d/%0d", sent, recv, N, N);
    end
    for (int i = 0; i < LAT; i++) tick();
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drained: got out_valid %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_bubbles();
    logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_v;
    for (int c = 0; c < 10; c++) begin
      bus.out_ready = 1'b1;
      if (c < 5) begin
        bus.in_valid = pat[c]; bus.in_u = 64'(c + 1); bus.in_v = '0; bus.in_tag = TAG_W'(c + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      exp_v = (c >= LAT && c < LAT + 5) ? pat[c-LAT] : 1'b0;
      tests_run++;
      if (bus.out_valid !== exp_v) begin
        tests_failed++; $display("FAIL bubble_valid cycle %0d: got %b expected %b", c, bus.out_valid, exp_v);
      end else if (exp_v) begin
        tests_run++;
        if (bus.out_tag !== TAG_W'(c - LAT + 1) || bus.out_sum !== 64'(c - LAT + 1)) begin
          tests_failed++;
          $display("FAIL bubble_data cycle %0d: got tag=%h sum=%h expected tag=%h sum=%h", c,
                   bus.out_tag, bus.out_sum, TAG_W'(c - LAT + 1), 64'(c - LAT + 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_u = 64'hA5A5_0000_0000_0000 + 64'(i); bus.in_v = 64'h1;
      bus.in_tag = TAG_W'(7 + i);
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_sum !== '0 || bus.out_tag !== '0 || bus.out_cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midflight_reset_outputs: got v=%b sum=%h co=%b tag=%h expected all 0",
               bus.out_valid, bus.out_sum, bus.out_cout, bus.out_tag);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL midflight_ghost cycle %0d: got out_valid %b tag %h expected 0",
                                 c, bus.out_valid, bus.out_tag);
      end
    end
  endtask

  task automatic test_reset_midstall();
    for (int i = 0; i < LAT; i++) begin
      bus.in_valid = 1'b1; bus.in_u = 64'(i + 1); bus.in_v = 64'(i + 1); bus.in_tag = TAG_W'(i + 1);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.in_tag    = TAG_W'(5);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== 64'd2) begin
      tests_failed++;
      $display("FAIL stall_setup: got v=%b rdy=%b sum=%h expected v=1 rdy=0 sum=2",
               bus.out_valid, bus.in_ready, bus.out_sum);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_sum !== '0 || bus.out_tag !== '0) begin
      tests_failed++;
      $display("FAIL stall_reset: got v=%b rdy=%b sum=%h tag=%h expected v=0 rdy=1 sum=0 tag=0",
               bus.out_valid, bus.in_ready, bus.out_sum, bus.out_tag);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stall_release_ready: got %b expected 1", bus.in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
        tests_failed++; $display("FAIL stall_ghost cycle %0d: got out_valid %b expected 0", c, bus.out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_reset_midstall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
`default_nettype wire
